// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b, one bit per clock, LSB first.
// A single full-subtractor cell and a registered borrow walk the operands.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic x, y, d, bout, load;

    // Full-subtractor cell
    assign x    = a_q[0];
    assign y    = b_q[0];
    assign d    = x ^ y ^ brw_q;
    assign bout = (~x & y) | (~(x ^ y) & brw_q);

    // A start is only honoured when no operation is in flight.
    assign load = start && (state_q != StRun);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d, res_q[WIDTH-1:1]};
                brw_d = bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LastBit) begin
                    state_d = StDone;
                    // Publish results on the edge that enters DONE so they show with done.
                    diff_d  = {d, res_q[WIDTH-1:1]};
                    bout_d  = bout;
                    ovf_d   = (amsb_q ^ bmsb_q) & (d ^ amsb_q);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            state_d = StRun;
            a_d     = a;
            b_d     = b;
            res_d   = '0;
            cnt_d   = '0;
            brw_d   = 1'b0;
            amsb_d  = a[WIDTH-1];
            bmsb_d  = b[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q == StRun);
    assign done       = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors, expectations queued at issue
// and checked by an independent monitor whenever done pulses.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic       overflow;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ndone  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (done && busy) chk("done_and_busy", 32'd1, 32'd0);
            if (done) begin
                exp_t e;
                ndone++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("diff", {24'd0, diff}, {24'd0, e.d});
                    chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.br});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ed, input logic ebr, input logic eov);
        exp_t e;
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        e.d   = ed;
        e.br  = ebr;
        e.ov  = eov;
        e.cyc = cyc + 1 + 8;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        int  nd;
        bit  seen;
        nd    = ndone;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nbusy++;
            @(negedge clk);
            #1;
            if (ndone != nd) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_diff"}, {24'd0, diff}, 32'd0);
        chk({tag, "_borrow"}, {31'd0, borrow_out}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        int nb;
        int nd;
        bit fin;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        wait_done(nb);
        chk("busy_cycles", nb, 32'd8);

        issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        wait_done(nb);
        issue(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done(nb);
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        wait_done(nb);
        issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        wait_done(nb);

        // start during RUN must be ignored
        issue(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        nd = ndone;
        repeat (15) @(negedge clk);
        chk("no_second_done", ndone, nd);

        // Reset in the middle of RUN aborts the operation
        issue(8'h40, 8'h01, 8'h3F, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midrun_reset");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        nd  = ndone;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", ndone, nd);
        chk("idle_after_abort", {31'd0, busy}, 32'd0);
        issue(8'h20, 8'h10, 8'h10, 1'b0, 1'b0);
        wait_done(nb);

        // Back-to-back start in the DONE cycle; previous result must hold
        issue(8'h44, 8'h11, 8'h33, 1'b0, 1'b0);
        wait_done(nb);
        chk("in_done_cycle", {31'd0, done}, 32'd1);
        begin
            exp_t e;
            a     = 8'h00;
            b     = 8'h01;
            start = 1'b1;
            e.d   = 8'hFF;
            e.br  = 1'b1;
            e.ov  = 1'b0;
            e.cyc = cyc + 1 + 8;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        nd    = ndone;
        fin   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) chk("held_diff", {24'd0, diff}, 32'h33);
            @(negedge clk);
            #1;
            if (ndone != nd) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk("b2b_timeout", 32'd0, 32'd1);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
